fetch_queue: RTL

Instruction prefetch buffer between the fetch stage and the decode stage of the 5-stage pipeline. It decouples the fetch stage from decode stalls by holding up to DEPTH fetched instruction/address pairs. It presents the oldest entry to decode in first-word-fall-through order. A taken branch resolved in execute discards every queued entry.

---
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 92 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// The master side is the pipeline (fetch, decode, execute); the slave side is the queue.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 16,
    parameter int unsigned AW    = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          fe_valid;
    logic [IW-1:0] fe_instr;
    logic [AW-1:0] fe_instr_addr;
    logic          fe_ready;
    logic          id_stall;
    logic          flush;
    logic          id_valid;
    logic [IW-1:0] id_instr;
    logic [AW-1:0] id_instr_addr;
    logic [CW-1:0] count;
    logic [7:0]    flush_cnt;

    modport master (
        output fe_valid, fe_instr, fe_instr_addr, id_stall, flush,
        input  fe_ready, id_valid, id_instr, id_instr_addr, count, flush_cnt
    );

    modport slave (
        input  fe_valid, fe_instr, fe_instr_addr, id_stall, flush,
        output fe_ready, id_valid, id_instr, id_instr_addr, count, flush_cnt
    );
endinterface

// File: rtl/fetch_queue.sv
// First-word-fall-through prefetch queue between fetch and decode.
// A taken-branch flush empties the queue and bumps a saturating event counter.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IW    = 16,
    parameter int unsigned AW    = 16
) (
    input  logic         CLOCK_50,
    input  logic         KEY,
    fetch_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [IW-1:0] instr_mem [DEPTH];
    logic [AW-1:0] addr_mem  [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    flush_cnt_q, flush_cnt_d;

    logic full;
    logic not_empty;
    logic push;
    logic pop;

    // Readiness depends on stored occupancy only, so a full queue refuses a push
    // even when decode pops in the same cycle.
    always_comb begin
        full      = (count_q == CW'(DEPTH));
        not_empty = (count_q != '0);
        push      = bus.fe_valid && !full && !bus.flush;
        pop       = not_empty && !bus.id_stall && !bus.flush;
    end

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            if (flush_cnt_q != 8'hFF) begin
                flush_cnt_d = flush_cnt_q + 8'd1;
            end
        end else begin
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Entry storage is never cleared; stale slots are masked by the occupancy count.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            instr_mem[tail_q] <= bus.fe_instr;
            addr_mem[tail_q]  <= bus.fe_instr_addr;
        end
    end

    assign bus.fe_ready      = !full;
    assign bus.id_valid      = not_empty;
    assign bus.id_instr      = not_empty ? instr_mem[head_q] : '0;
    assign bus.id_instr_addr = not_empty ? addr_mem[head_q] : '0;
    assign bus.count         = count_q;
    assign bus.flush_cnt     = flush_cnt_q;
endmodule
